ysyx_23060077_icache: RTL and testbench

YSYX_23060077_ICACHE -- requirements
Module: ysyx_23060077_icache

---
 rtl/ysyx_23060077_icache.sv | 99 +++++++++
 tb/tb_ysyx_23060077_icache.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_icache.sv
// ysyx_23060077_icache: direct-mapped instruction cache with a burst refill port.
// Hits answer the cycle after the request; misses refill the whole line, then answer from the array.
module ysyx_23060077_icache #(
    parameter int LINE_NUM   = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        aclk,
    input  logic        areset_n,
    input  logic        ifu_valid_i,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_ready_o,
    output logic [31:0] ifu_data_o,
    input  logic        fence_i_i,
    output logic        Icache_r_valid_o,
    output logic [31:0] Icache_r_addr_o,
    output logic [7:0]  Icache_r_len_o,
    input  logic        Icache_r_ready_i,
    input  logic [31:0] Icache_r_data_i,
    input  logic        Icache_r_last_i
);
    localparam int OFF_W = $clog2(LINE_WORDS * 4);
    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int WD_W  = $clog2(LINE_WORDS);
    localparam int TAG_W = 32 - OFF_W - IDX_W;
    localparam logic [WD_W-1:0] LAST_BEAT = WD_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_e;

    state_e                state_q, state_d;
    logic [31:2]           req_addr_q, req_addr_d;
    logic [LINE_NUM-1:0]   valid_q, valid_d;
    logic [WD_W-1:0]       beat_q, beat_d;
    logic                  discard_q, discard_d;
    logic [31:0]           data_mem [LINE_NUM*LINE_WORDS];
    logic [TAG_W-1:0]      tag_mem [LINE_NUM];
    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [WD_W-1:0]       word;
    logic                  hit, beat_acc, last_acc, line_ok;
    logic                  unused;

    assign unused   = ^ifu_addr_i[1:0];
    assign idx      = req_addr_q[OFF_W +: IDX_W];
    assign tag      = req_addr_q[31 -: TAG_W];
    assign word     = req_addr_q[2 +: WD_W];
    assign hit      = state_q == LOOKUP && valid_q[idx] && tag_mem[idx] == tag;
    assign beat_acc = state_q == REFILL && Icache_r_ready_i;
    assign last_acc = beat_acc && Icache_r_last_i;
    // A line is only trusted if every beat landed and no fence hit during the burst.
    assign line_ok  = !discard_q && !fence_i_i && beat_q == LAST_BEAT;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            valid_q    <= '0;
            beat_q     <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            valid_q    <= valid_d;
            beat_q     <= beat_d;
            discard_q  <= discard_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (beat_acc) data_mem[{idx, beat_q}] <= Icache_r_data_i;
        if (last_acc) tag_mem[idx] <= tag;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ifu_valid_i ? LOOKUP : IDLE;
            LOOKUP:  state_d = hit ? IDLE : REFILL;
            REFILL:  state_d = last_acc ? RESP : REFILL;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_addr_d = (state_q == IDLE && ifu_valid_i) ? ifu_addr_i[31:2] : req_addr_q;
        beat_d     = state_q == LOOKUP ? '0 :
                     (beat_acc && beat_q != LAST_BEAT) ? beat_q + 1'b1 : beat_q;
        discard_d  = state_q == REFILL && (discard_q || fence_i_i);
        valid_d    = fence_i_i ? '0 : valid_q;
        if (last_acc) valid_d[idx] = line_ok;
    end

    always_comb begin
        ifu_ready_o      = hit || state_q == RESP;
        ifu_data_o       = ifu_ready_o ? data_mem[{idx, word}] : '0;
        Icache_r_valid_o = state_q == REFILL;
        Icache_r_addr_o  = Icache_r_valid_o ? {req_addr_q[31:OFF_W], OFF_W'(0)} : '0;
        Icache_r_len_o   = Icache_r_valid_o ? 8'(LINE_WORDS - 1) : '0;
    end
endmodule

// File: tb/tb_ysyx_23060077_icache.sv
// tb_ysyx_23060077_icache: random and directed fetches against a line-presence model of the cache;
// expected words are queued at issue and checked by an independent output monitor.
module tb_ysyx_23060077_icache;
    localparam int LN = 16;
    localparam int LW = 4;

    logic        aclk = 0;
    logic        areset_n = 1;
    logic        ifu_valid_i = 0;
    logic [31:0] ifu_addr_i = 0;
    logic        ifu_ready_o;
    logic [31:0] ifu_data_o;
    logic        fence_i_i = 0;
    logic        Icache_r_valid_o;
    logic [31:0] Icache_r_addr_o;
    logic [7:0]  Icache_r_len_o;
    logic        Icache_r_ready_i = 0;
    logic [31:0] Icache_r_data_i = 0;
    logic        Icache_r_last_i = 0;

    ysyx_23060077_icache #(.LINE_NUM(LN), .LINE_WORDS(LW)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .ifu_valid_i(ifu_valid_i), .ifu_addr_i(ifu_addr_i),
        .ifu_ready_o(ifu_ready_o), .ifu_data_o(ifu_data_o),
        .fence_i_i(fence_i_i),
        .Icache_r_valid_o(Icache_r_valid_o), .Icache_r_addr_o(Icache_r_addr_o),
        .Icache_r_len_o(Icache_r_len_o), .Icache_r_ready_i(Icache_r_ready_i),
        .Icache_r_data_i(Icache_r_data_i), .Icache_r_last_i(Icache_r_last_i)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        logic        hit;
        int          issue;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic        mv[LN];
    logic [23:0] mt[LN];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h3000000) return ({30'b0, a[3:2]} + 32'd1) * 32'h11;
        return {a[15:2], 2'b01, ~a[17:2]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin : monitor
        exp_t e;
        if (areset_n) begin
            if (ifu_ready_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got data %h expected no response", ifu_data_o);
                end else begin
                    e = sb.pop_front();
                    check("ifu_data", ifu_data_o, e.data);
                    if (e.hit) check("hit_latency", cyc - e.issue, 1);
                    else check("miss_latency_gt1", 32'(cyc - e.issue > 1), 1);
                end
                done_cnt++;
            end else check("data_zero_when_idle", ifu_data_o, 0);
            if (!Icache_r_valid_o)
                check("bus_zero_when_idle", Icache_r_addr_o | 32'(Icache_r_len_o), 0);
        end
    end

    task automatic clear_model();
        for (int i = 0; i < LN; i++) mv[i] = 0;
    endtask

    task automatic fence_pulse();
        @(negedge aclk);
        fence_i_i = 1;
        @(negedge aclk);
        fence_i_i = 0;
        clear_model();
    endtask

    // mode: 0 normal, 1 fence mid-refill, 2 short burst (last on 3rd beat), 3 reset on 3rd beat
    task automatic fetch(input logic [31:0] a, input bit gaps, input int mode);
        logic [3:0]  idx;
        logic [23:0] tg;
        logic [31:0] line;
        bit          hit, abort, rdy;
        int          b, n, tgt, nb;
        idx   = a[7:4];
        tg    = a[31:8];
        line  = {a[31:4], 4'b0};
        hit   = mv[idx] && mt[idx] == tg;
        abort = mode == 3 && !hit;
        nb    = mode == 2 ? 3 : LW;
        @(negedge aclk);
        tgt = done_cnt + 1;
        if (!abort) sb.push_back('{mem_word(a), hit, cyc});
        ifu_valid_i = 1;
        ifu_addr_i  = a;
        @(negedge aclk);
        ifu_valid_i = 0;
        ifu_addr_i  = $urandom;
        if (!hit) begin
            n = 0;
            while (!Icache_r_valid_o && n < 8) begin
                @(negedge aclk);
                n++;
            end
            check("refill_req", 32'(Icache_r_valid_o), 1);
            check("refill_addr", Icache_r_addr_o, line);
            check("refill_len", 32'(Icache_r_len_o), LW - 1);
            b = 0;
            while (b < nb) begin
                check("refill_valid_held", 32'(Icache_r_valid_o), 1);
                rdy = !gaps || $urandom_range(0, 1) == 1;
                Icache_r_ready_i = rdy;
                Icache_r_data_i  = rdy ? mem_word(line + 32'(4 * b)) : 32'hdead_beef;
                Icache_r_last_i  = rdy ? (b == nb - 1) : ($urandom_range(0, 1) == 1);
                fence_i_i        = mode == 1 && b == 1 && rdy;
                if (mode == 3 && b == 2) begin
                    areset_n = 0;
                    #1;
                    check("reset_r_valid", 32'(Icache_r_valid_o), 0);
                    check("reset_r_addr", Icache_r_addr_o, 0);
                    check("reset_ready", 32'(ifu_ready_o), 0);
                    @(negedge aclk);
                    areset_n = 1;
                    break;
                end
                @(negedge aclk);
                if (rdy) b++;
            end
            Icache_r_ready_i = 0;
            Icache_r_last_i  = 0;
            Icache_r_data_i  = 0;
            fence_i_i        = 0;
            if (!abort) check("refill_drop", 32'(Icache_r_valid_o), 0);
            if (mode == 1 || mode == 3) clear_model();
            else begin
                mv[idx] = mode != 2;
                mt[idx] = tg;
            end
        end
        if (!abort) begin
            n = 0;
            while (done_cnt < tgt && n < 50) begin
                @(negedge aclk);
                n++;
            end
            check("response_seen", 32'(done_cnt >= tgt), 1);
        end
    endtask

    initial begin
        logic [31:0] a;
        int md, mode;
        clear_model();
        #1 areset_n = 0;
        repeat (2) @(negedge aclk);
        check("rst_ready", 32'(ifu_ready_o), 0);
        check("rst_data", ifu_data_o, 0);
        check("rst_r_valid", 32'(Icache_r_valid_o), 0);
        check("rst_r_addr", Icache_r_addr_o, 0);
        check("rst_r_len", 32'(Icache_r_len_o), 0);
        areset_n = 1;
        fetch(32'h3000_0004, 0, 0);
        fetch(32'h3000_0008, 0, 0);
        fetch(32'h3000_0100, 0, 0);
        fetch(32'h3000_0000, 0, 0);
        fetch(32'h8000_0040, 0, 1);
        fetch(32'h8000_0040, 0, 0);
        fetch(32'h8000_0044, 0, 0);
        fetch(32'h8000_0084, 1, 0);
        fetch(32'h8000_0088, 0, 0);
        fetch(32'h8000_00c4, 0, 2);
        fetch(32'h8000_00c4, 0, 0);
        fetch(32'h8000_0104, 0, 3);
        fetch(32'h8000_0104, 0, 0);
        fence_pulse();
        fetch(32'h3000_0008, 0, 0);
        for (int i = 0; i < 150; i++) begin
            a = 32'h8000_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 63) << 2);
            md = $urandom_range(0, 9);
            mode = md == 0 ? 1 : (md == 1 && a[3:2] != 2'd3) ? 2 : 0;
            if ($urandom_range(0, 15) == 0) fence_pulse();
            fetch(a, $urandom_range(0, 1) == 1, mode);
        end
        repeat (3) @(negedge aclk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
